comp_search_initiator: RTL and testbench
========================================

Name: comp_search_initiator

Overview:
- Sequential initiator that drives a three-output magnitude comparator (greater / equal / less) from the other end of its interface.
- Runs a binary search to find a hidden WIDTH-bit operand held by the comparator side. Each cycle of the search issues a probe value, consumes the one-hot gt/eq/lt verdict and narrows the range [lo,hi].
- Sits in front of the comparator netlist as its stimulus/consumer; used for self-checking comparator harnesses and value-recovery flows.

Parameters:
- WIDTH, 16, operand width in bits; probe and result width.
- MAX_PROBES, WIDTH+1, hard cap on probes per search.
- TIMEOUT, 64, response-wait cycles (only with COMP_SEARCH_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a search; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- probe_valid  out  1  probe_data is valid
- probe_ready  in  1  comparator side accepts the probe
- probe_data  out  WIDTH  value presented as comparator operand A
- resp_valid  in  1  verdict valid
- resp_gt  in  1  probe > hidden operand
- resp_eq  in  1  probe == hidden operand
- resp_lt  in  1  probe < hidden operand
- done  out  1  one-cycle pulse at end of search
- found  out  1  search ended on eq; held until next start
- result  out  WIDTH  matched value; held until next start
- probe_count  out  $clog2(MAX_PROBES+1)  probes issued in last/current search
- error  out  1  sticky until next start: non-one-hot verdict or timeout

Behaviour:
- Reset: state=IDLE. All outputs 0: busy, probe_valid, probe_data, done, found, result, probe_count, error. lo=0, hi=2^WIDTH-1.
- Reset mid-search aborts immediately, with no done pulse.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - start=1 → load lo=0, hi=all-ones, clear found/result/error/probe_count → ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - probe_valid=1, probe_data = lo + ((hi-lo)>>1), computed in WIDTH+1 bits and held stable while probe_valid && !probe_ready.
  - On probe_valid && probe_ready: probe_count++ → WAIT.
- WAIT:
  - resp_valid sampled. resp_valid outside WAIT is ignored.
  - eq only → found=1, result=probe → FINISH.
  - gt only → hi = probe-1.
  - lt only → lo = probe+1.
  - Then if the range is empty (lo>hi in WIDTH+1 bits, covering probe=0 with gt and probe=all-ones with lt) or probe_count==MAX_PROBES → FINISH with found=0. Otherwise → ISSUE.
  - Verdict not exactly one-hot (including all zero with resp_valid) → error=1, found=0 → FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 → IDLE.
- Latency: with probe_ready=1 and a response the cycle after acceptance, each probe takes 2 cycles. A consistent comparator finishes in ≤WIDTH+1 probes.
- probe_data is held at the last probe value after the search ends.

Optional Feature:
- COMP_SEARCH_TIMEOUT_EN defined:
  - A counter in WAIT increments each cycle without resp_valid.
  - On reaching TIMEOUT: error=1, found=0 → FINISH.
  - The counter clears on entering WAIT.
- Undefined: WAIT holds indefinitely; no counter logic is present.

Decomposition:
- Shared package comp_search_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, FINISH)
  - verdict encoding constants (GT=3'b100, EQ=3'b010, LT=3'b001)
  - a function is_onehot3
- One natural sub-module: comp_search_range, which holds lo/hi registers, the midpoint computation and the empty-range flag. The FSM stays in the top.

Test Plan:
- Hidden operand 0x7FFF, ideal comparator (probe_ready=1, response 1 cycle later) → 1 probe, found=1, result=0x7FFF, done pulse 3 cycles after start.
- Hidden 0x0000 and 0xFFFF → found=1, result equals operand, probe_count ≤17, error=0.
- Stuck-gt responder → hi underflows at probe 0x0000 → done, found=0, error=0, probe_count ≤17.
- Response gt=1, lt=1 on first probe → error=1, found=0, done next cycle. The next start clears error.
- probe_ready low for 5 cycles → probe_data stable and probe_count unchanged until the handshake. Start pulsed while busy → ignored.
- COMP_SEARCH_TIMEOUT_EN with TIMEOUT=64 and no responder → error=1 and done after 64 WAIT cycles. Reset asserted mid-search → all outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/comp_search_pkg.sv
// Shared types for the binary-search comparator initiator: FSM states,
// the {gt,eq,lt} verdict encoding and a one-hot check for that verdict.
package comp_search_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == GT) || (v == EQ) || (v == LT);
  endfunction

endpackage

// File: rtl/comp_search_range.sv
// Search window [lo,hi] for the initiator: holds the bounds, produces the
// midpoint probe and flags when the pending update would empty the window.
module comp_search_range #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             upd_gt,
  input  logic             upd_lt,
  input  logic [WIDTH-1:0] probe,
  output logic [WIDTH-1:0] mid,
  output logic             empty_next
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      lo <= '0;
      hi <= '1;
    end else if (upd_gt) begin
      hi <= probe - WIDTH'(1);
    end else if (upd_lt) begin
      lo <= probe + WIDTH'(1);
    end
  end

  // hi >= lo whenever a probe is issued, so hi-lo never wraps and mid <= hi.
  assign mid = lo + ((hi - lo) >> 1);

  // The probe is always inside [lo,hi]; the window empties exactly when the
  // verdict excludes the bound the probe sits on (also covers 0/gt, ones/lt).
  assign empty_next = (upd_gt && (probe == lo)) || (upd_lt && (probe == hi));

endmodule

// File: rtl/comp_search_initiator.sv
// Binary-search initiator driving a gt/eq/lt comparator to recover a hidden
// operand. Define COMP_SEARCH_TIMEOUT_EN to bound the wait for each verdict.
module comp_search_initiator
  import comp_search_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_PROBES = WIDTH + 1
`ifdef COMP_SEARCH_TIMEOUT_EN
  , parameter int TIMEOUT  = 64
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               probe_valid,
  input  logic                               probe_ready,
  output logic [WIDTH-1:0]                   probe_data,
  input  logic                               resp_valid,
  input  logic                               resp_gt,
  input  logic                               resp_eq,
  input  logic                               resp_lt,
  output logic                               done,
  output logic                               found,
  output logic [WIDTH-1:0]                   result,
  output logic [$clog2(MAX_PROBES+1)-1:0]    probe_count,
  output logic                               error
);

  localparam int CW = $clog2(MAX_PROBES + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] probe_q;
  logic [WIDTH-1:0] mid;
  logic [2:0]       verdict;
  logic             load, accept, resp_ok, bad_verdict, hit, upd_gt, upd_lt;
  logic             empty_next, timed_out;

  assign verdict     = {resp_gt, resp_eq, resp_lt};
  assign load        = (state == IDLE) && start;
  assign accept      = (state == ISSUE) && probe_ready;
  assign resp_ok     = (state == WAIT) && resp_valid;
  assign bad_verdict = resp_ok && !is_onehot3(verdict);
  assign hit         = resp_ok && (verdict == EQ);
  assign upd_gt      = resp_ok && (verdict == GT);
  assign upd_lt      = resp_ok && (verdict == LT);

  comp_search_range #(.WIDTH(WIDTH)) u_range (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .upd_gt     (upd_gt),
    .upd_lt     (upd_lt),
    .probe      (probe_q),
    .mid        (mid),
    .empty_next (empty_next)
  );

`ifdef COMP_SEARCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !resp_valid) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  assign timed_out = (state == WAIT) && !resp_valid && (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: defaults first so every path assigns state_n and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = ISSUE;
      ISSUE:  if (probe_ready) state_n = WAIT;
      WAIT: begin
        if (timed_out || bad_verdict || hit) begin
          state_n = FINISH;
        end else if (resp_valid) begin
          state_n = (empty_next || (probe_count == CW'(MAX_PROBES))) ? FINISH : ISSUE;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      probe_q     <= '0;
      found       <= 1'b0;
      result      <= '0;
      probe_count <= '0;
      error       <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        found       <= 1'b0;
        result      <= '0;
        error       <= 1'b0;
        probe_count <= '0;
      end
      if (accept) begin
        probe_q     <= mid;
        probe_count <= probe_count + CW'(1);
      end
      if (hit) begin
        found  <= 1'b1;
        result <= probe_q;
      end
      if (bad_verdict || timed_out) begin
        error <= 1'b1;
        found <= 1'b0;
      end
    end
  end

  assign busy        = (state == ISSUE) || (state == WAIT);
  assign probe_valid = (state == ISSUE);
  assign done        = (state == FINISH);
  // The live midpoint is shown while offering; afterwards the last issued probe.
  assign probe_data  = (state == ISSUE) ? mid : probe_q;

endmodule

// File: tb/tb_comp_search_initiator.sv
// Self-checking bench for comp_search_initiator: integer reference model of the
// binary search compared every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_comp_search_initiator;

  localparam int     WIDTH = 16;
  localparam int     MAXP  = WIDTH + 1;
  localparam int     CW    = $clog2(MAXP + 1);
  localparam longint ALL1  = (longint'(1) << WIDTH) - 1;
`ifdef COMP_SEARCH_TIMEOUT_EN
  localparam int     TIMEOUT = 64;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, probe_ready = 1'b1;
  logic resp_valid = 1'b0, resp_gt = 1'b0, resp_eq = 1'b0, resp_lt = 1'b0;
  logic busy, probe_valid, done, found, error;
  logic [WIDTH-1:0] probe_data, result;
  logic [CW-1:0] probe_count;

  comp_search_initiator #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .probe_valid(probe_valid), .probe_ready(probe_ready), .probe_data(probe_data),
    .resp_valid(resp_valid), .resp_gt(resp_gt), .resp_eq(resp_eq), .resp_lt(resp_lt),
    .done(done), .found(found), .result(result), .probe_count(probe_count), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: 0 ideal comparator, 1 stuck gt, 2 gt+lt, 3 silent, 4 valid with no bits
  int               mode = 0;
  logic [WIDTH-1:0] hidden = '0;
  bit               rand_ready = 1'b0;
  int               resp_dmax = 0;
  int               ready_block = 0;
  logic             hs, rst_seen;
  logic [WIDTH-1:0] cap_probe;
  bit               pend = 1'b0;
  int               dleft = 0;

  always @(posedge clk) begin
    hs       = probe_valid && probe_ready;
    rst_seen = rst;
    if (hs) cap_probe = probe_data;
    #2;
    resp_valid = 1'b0; resp_gt = 1'b0; resp_eq = 1'b0; resp_lt = 1'b0;
    if (rst_seen) begin
      pend = 1'b0;
    end else if (hs === 1'b1) begin
      pend  = 1'b1;
      dleft = $urandom_range(resp_dmax, 0);
    end
    if (pend && dleft == 0) begin
      pend = 1'b0;
      case (mode)
        0: begin
          resp_valid = 1'b1;
          resp_gt = (cap_probe > hidden);
          resp_eq = (cap_probe == hidden);
          resp_lt = (cap_probe < hidden);
        end
        1: begin resp_valid = 1'b1; resp_gt = 1'b1; end
        2: begin resp_valid = 1'b1; resp_gt = 1'b1; resp_lt = 1'b1; end
        4: resp_valid = 1'b1;
        default: ;
      endcase
    end else if (pend) begin
      dleft--;
    end
    if (ready_block > 0) begin
      probe_ready = 1'b0;
      ready_block--;
    end else begin
      probe_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
    end
  end

  // Reference model: ph 0 idle, 1 offering a probe, 2 awaiting verdict, 3 done
  int     ph = 0, m_cnt = 0, m_wcnt = 0, ones;
  longint m_lo = 0, m_hi = ALL1, m_probe = 0, m_result = 0;
  bit     m_found = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; m_lo = 0; m_hi = ALL1; m_probe = 0; m_cnt = 0; m_wcnt = 0;
      m_found = 1'b0; m_result = 0; m_err = 1'b0;
    end else begin
      case (ph)
        0: if (start) begin
          m_lo = 0; m_hi = ALL1; m_cnt = 0; m_found = 1'b0; m_result = 0; m_err = 1'b0;
          ph = 1;
        end
        1: if (probe_ready) begin
          m_probe = m_lo + (m_hi - m_lo) / 2;
          m_cnt++;
          m_wcnt = 0;
          ph = 2;
        end
        2: if (resp_valid) begin
          ones = int'(resp_gt) + int'(resp_eq) + int'(resp_lt);
          if (ones != 1) begin
            m_err = 1'b1; m_found = 1'b0; ph = 3;
          end else if (resp_eq) begin
            m_found = 1'b1; m_result = m_probe; ph = 3;
          end else begin
            if (resp_gt) m_hi = m_probe - 1;
            else         m_lo = m_probe + 1;
            ph = (m_lo > m_hi || m_cnt == MAXP) ? 3 : 1;
          end
        end
`ifdef COMP_SEARCH_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == TIMEOUT) begin
            m_err = 1'b1; m_found = 1'b0; ph = 3;
          end
        end
`endif
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy", busy, 64'(ph == 1 || ph == 2));
      check("probe_valid", probe_valid, 64'(ph == 1));
      check("probe_data", probe_data, (ph == 1) ? m_lo + (m_hi - m_lo) / 2 : m_probe);
      check("done", done, 64'(ph == 3));
      check("found", found, 64'(m_found));
      check("result", result, m_result);
      check("probe_count", probe_count, 64'(m_cnt));
      check("error", error, 64'(m_err));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat = clock edges from start sampled until done observed
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 4000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_within_bound", 64'(done === 1'b1), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_probe_valid"}, probe_valid, 0);
    check({tag, "_probe_data"}, probe_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_probe_count"}, probe_count, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int lat;
  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Hidden value at the first midpoint: single probe, done in cycle 3
    mode = 0; hidden = 16'h7FFF;
    pulse_start(); wait_done(lat);
    check("lat_7fff", lat, 3);
    check("found_7fff", found, 1);
    check("result_7fff", result, 16'h7FFF);
    check("count_7fff", probe_count, 1);
    check("error_7fff", error, 0);

    hidden = 16'h0000;
    pulse_start(); wait_done(lat);
    check("found_0000", found, 1);
    check("result_0000", result, 16'h0000);
    check("count_0000", probe_count, 16);
    check("error_0000", error, 0);

    hidden = 16'hFFFF;
    pulse_start(); wait_done(lat);
    check("found_ffff", found, 1);
    check("result_ffff", result, 16'hFFFF);
    check("count_ffff", probe_count, 17);
    check("error_ffff", error, 0);

    // Stuck-gt walks down to probe 0 and empties the window
    mode = 1;
    pulse_start(); wait_done(lat);
    check("found_stuck", found, 0);
    check("error_stuck", error, 0);
    check("count_stuck", probe_count, 16);

    // gt and lt together on the first probe
    mode = 2;
    pulse_start(); wait_done(lat);
    check("lat_bad", lat, 3);
    check("error_bad", error, 1);
    check("found_bad", found, 0);
    check("count_bad", probe_count, 1);

    mode = 0; hidden = 16'h1234;
    pulse_start();
    check("error_cleared", error, 0);
    wait_done(lat);
    check("result_1234", result, 16'h1234);

    mode = 4;
    pulse_start(); wait_done(lat);
    check("error_zero_verdict", error, 1);

    // Stall the handshake; a start pulse while busy must be ignored
    mode = 0; hidden = 16'hABCD; ready_block = 6;
    pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("stall_valid", probe_valid, 1);
    check("stall_data", probe_data, 16'h7FFF);
    check("stall_count", probe_count, 0);
    wait_done(lat);
    check("found_abcd", found, 1);
    check("result_abcd", result, 16'hABCD);

    // Random operands, random ready and verdict delays
    rand_ready = 1'b1; resp_dmax = 3;
    for (int i = 0; i < 40; i++) begin
      hidden = WIDTH'($urandom);
      mode   = ($urandom_range(9, 0) == 0) ? 2 : 0;
      pulse_start(); wait_done(lat);
      if (mode == 0) check("rand_result", result, hidden);
    end

    // Reset mid-search with a silent responder
    rand_ready = 1'b0; resp_dmax = 0; mode = 3;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", busy, 0);

`ifdef COMP_SEARCH_TIMEOUT_EN
    mode = 3;
    pulse_start(); wait_done(lat);
    check("lat_timeout", lat, 2 + TIMEOUT);
    check("error_timeout", error, 1);
    check("found_timeout", found, 0);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
